// File: rtl/accel_pkg.sv
`default_nettype none
// =====================================================================
// accel_pkg: shared constants and dispatcher state encoding. Rev 1.0
// =====================================================================
package accel_pkg;

  localparam int unsigned ACC_DATA_W  = 16;
  localparam int unsigned ACC_RES_W   = 16;
  localparam int unsigned ACC_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    DISP_IDLE      = 3'd0,
    DISP_ARM       = 3'd1,
    DISP_FIRE      = 3'd2,
    DISP_WAIT_ACK  = 3'd3,
    DISP_WAIT_DONE = 3'd4,
    DISP_OUT       = 3'd5
  } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/dispatch_timeout_cnt.sv
`default_nettype none
// =====================================================================
// dispatch_timeout_cnt: job watchdog with clear/enable/expired. Rev 1.0
// =====================================================================
module dispatch_timeout_cnt
  import accel_pkg::*;
#(
  parameter int unsigned TIMEOUT = ACC_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Holds cycles elapsed since the start pulse; the pulse cycle itself counts as one.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= CNT_W'(1);
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/accel_dispatcher.sv
`default_nettype none
// =====================================================================
// accel_dispatcher: serialises jobs onto the accelerator start/ready handshake.
// Optional watchdog enabled by ACC_DISPATCH_TIMEOUT_EN. Rev 1.0
// =====================================================================
module accel_dispatcher
  import accel_pkg::*;
#(
  parameter int unsigned DATA_W  = ACC_DATA_W,
  parameter int unsigned RES_W   = ACC_RES_W,
  parameter int unsigned TIMEOUT = ACC_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              acc_start,
  output logic [DATA_W-1:0] acc_x,
  input  logic              acc_ready,
  input  logic [RES_W-1:0]  acc_result,
  output logic              out_valid,
  output logic [RES_W-1:0]  out_data,
  output logic              out_err,
  input  logic              out_ready,
  output logic              busy
);

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("accel_dispatcher: TIMEOUT must be at least 2");
  end

  disp_state_e       state_q;
  logic [DATA_W-1:0] acc_x_q;
  logic [RES_W-1:0]  out_data_q;
  logic              err_q;
  logic              timeout_hit;

`ifdef ACC_DISPATCH_TIMEOUT_EN
  logic cnt_clear;
  logic cnt_en;

  assign cnt_clear = (state_q == DISP_FIRE);
  assign cnt_en    = (state_q == DISP_WAIT_ACK) || (state_q == DISP_WAIT_DONE);

  dispatch_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_en),
    .expired_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= DISP_IDLE;
      acc_x_q    <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        DISP_IDLE: begin
          if (in_valid) begin
            acc_x_q <= in_data;
            state_q <= DISP_ARM;
          end
        end
        // Accelerator may still be busy with a job from before our reset.
        DISP_ARM: begin
          if (acc_ready) state_q <= DISP_FIRE;
        end
        DISP_FIRE: begin
          state_q <= DISP_WAIT_ACK;
        end
        DISP_WAIT_ACK: begin
          if (timeout_hit) begin
            out_data_q <= '0;
            err_q      <= 1'b1;
            state_q    <= DISP_OUT;
          end else if (!acc_ready) begin
            state_q <= DISP_WAIT_DONE;
          end
        end
        // A result arriving on the expiry cycle still wins over the abort.
        DISP_WAIT_DONE: begin
          if (acc_ready) begin
            out_data_q <= acc_result;
            err_q      <= 1'b0;
            state_q    <= DISP_OUT;
          end else if (timeout_hit) begin
            out_data_q <= '0;
            err_q      <= 1'b1;
            state_q    <= DISP_OUT;
          end
        end
        DISP_OUT: begin
          if (out_ready) state_q <= DISP_IDLE;
        end
        default: state_q <= DISP_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == DISP_IDLE);
  assign acc_start = (state_q == DISP_FIRE);
  assign out_valid = (state_q == DISP_OUT);
  assign busy      = (state_q != DISP_IDLE);
  assign acc_x     = acc_x_q;
  assign out_data  = out_data_q;
  assign out_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_dispatcher.sv
`default_nettype none
// =====================================================================
// tb_accel_dispatcher: directed vector table plus multi-cycle job sequences.
// Build with ACC_DISPATCH_TIMEOUT_EN to exercise the watchdog. Rev 1.0
// =====================================================================
module tb_accel_dispatcher;

  localparam int TB_TIMEOUT = 8;
`ifdef ACC_DISPATCH_TIMEOUT_EN
  localparam int BASIC_BUSY = 5;
`else
  localparam int BASIC_BUSY = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        acc_start;
  logic [15:0] acc_x;
  logic        acc_ready;
  logic [15:0] acc_result;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_err;
  logic        out_ready;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accel_dispatcher #(
    .DATA_W  (16),
    .RES_W   (16),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clock      (clk),
    .reset      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .acc_start  (acc_start),
    .acc_x      (acc_x),
    .acc_ready  (acc_ready),
    .acc_result (acc_result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        acc_ready;
    logic [15:0] acc_result;
    logic        out_ready;
    logic        e_in_ready;
    logic        e_start;
    logic        e_out_valid;
    logic        e_busy;
    logic [15:0] e_acc_x;
    logic [15:0] e_out_data;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iv, input logic [15:0] id,
                              input logic ar, input logic [15:0] res, input logic ordy,
                              input logic eir, input logic est, input logic eov,
                              input logic ebz, input logic [15:0] eax, input logic [15:0] eod);
    vec_t v;
    v.rst_n = r; v.in_valid = iv; v.in_data = id; v.acc_ready = ar;
    v.acc_result = res; v.out_ready = ordy;
    v.e_in_ready = eir; v.e_start = est; v.e_out_valid = eov; v.e_busy = ebz;
    v.e_acc_x = eax; v.e_out_data = eod;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One job through a cycle-level accelerator model: ready drops the cycle after
  // start is seen, stays low busy_len cycles, then returns with res.
  task automatic run_job(input logic [15:0] x, input logic [15:0] res,
                         input int busy_len, input int pre_busy);
    int  cyc;
    int  starts;
    int  k_out;
    int  left;
    bit  drop_next;
    bit  mine;
    bit  done;
    acc_ready = (pre_busy == 0);
    in_valid  = 1'b1;
    in_data   = x;
    out_ready = 1'b1;
    step();
    chk("accept_busy", 64'(busy), 64'd1);
    chk("accept_x", 64'(acc_x), 64'(x));
    in_valid  = 1'b0;
    in_data   = 16'hFFFF;
    cyc       = 1;
    starts    = 0;
    k_out     = 0;
    left      = pre_busy;
    drop_next = 1'b0;
    mine      = 1'b0;
    done      = 1'b0;
    while (!done && cyc < 200) begin
      if (acc_start) begin
        starts++;
        chk("start_needs_ready", 64'(acc_ready), 64'd1);
      end
      chk("acc_x_stable", 64'(acc_x), 64'(x));
      if (out_valid) begin
        done  = 1'b1;
        k_out = cyc;
        chk("job_out_data", 64'(out_data), 64'(res));
        chk("job_out_err", 64'(out_err), 64'd0);
      end
      if (drop_next) begin
        acc_ready = 1'b0;
        left      = busy_len;
        mine      = 1'b1;
        drop_next = 1'b0;
      end else if (!acc_ready && left > 0) begin
        left--;
        if (left == 0) begin
          acc_ready  = 1'b1;
          acc_result = mine ? res : 16'hDEAD;
        end
      end
      if (acc_start) drop_next = 1'b1;
      if (!done) begin
        step();
        cyc++;
      end
    end
    chk("job_done", 64'(done), 64'd1);
    chk("start_count", 64'(starts), 64'd1);
    if (pre_busy == 0) chk("job_latency", 64'(k_out), 64'(4 + busy_len));
    step();
    chk("out_one_cycle", 64'(out_valid), 64'd0);
    chk("idle_after_job", 64'(in_ready), 64'd1);
  endtask

  vec_t tbl[$];

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 16'h0;
    acc_ready  = 1'b1;
    acc_result = 16'h0;
    out_ready  = 1'b1;

    // reset hold with in_valid high, then a short job with 5 cycles of backpressure
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 16'hAAAA, 1, 16'h0000, 1,  1, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 1, 16'h0003, 1, 16'h0000, 1,  0, 0, 0, 1, 16'h0003, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0000, 1,  0, 1, 0, 1, 16'h0003, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0000, 1,  0, 0, 0, 1, 16'h0003, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0000, 1,  0, 0, 0, 1, 16'h0003, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0000, 1,  0, 0, 0, 1, 16'h0003, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 0, 1, 16'h0003, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 0, 1, 16'h0003, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h1234, 0,  0, 0, 1, 1, 16'h0003, 16'h1234));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 1, 16'h5555, 1, 16'h0BAD, 0,  0, 0, 1, 1, 16'h0003, 16'h1234));
    tbl.push_back(mk(1, 1, 16'h5555, 1, 16'h0BAD, 1,  1, 0, 0, 0, 16'h0003, 16'h1234));
    tbl.push_back(mk(1, 1, 16'h5555, 1, 16'h0BAD, 1,  0, 0, 0, 1, 16'h5555, 16'h1234));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0000, 1,  1, 0, 0, 0, 16'h0000, 16'h0000));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n      = tbl[i].rst_n;
      in_valid   = tbl[i].in_valid;
      in_data    = tbl[i].in_data;
      acc_ready  = tbl[i].acc_ready;
      acc_result = tbl[i].acc_result;
      out_ready  = tbl[i].out_ready;
      step();
      n_vec++;
      if ({in_ready, acc_start, out_valid, busy, out_err, acc_x, out_data} !==
          {tbl[i].e_in_ready, tbl[i].e_start, tbl[i].e_out_valid, tbl[i].e_busy, 1'b0,
           tbl[i].e_acc_x, tbl[i].e_out_data}) begin
        n_err++;
        $display("FAIL vec%0d: got rdy=%b st=%b ov=%b bz=%b err=%b x=%h od=%h, expected rdy=%b st=%b ov=%b bz=%b err=0 x=%h od=%h",
                 i, in_ready, acc_start, out_valid, busy, out_err, acc_x, out_data,
                 tbl[i].e_in_ready, tbl[i].e_start, tbl[i].e_out_valid, tbl[i].e_busy,
                 tbl[i].e_acc_x, tbl[i].e_out_data);
      end
    end
    rst_n = 1'b1;

    run_job(16'h0003, 16'h1234, BASIC_BUSY, 0);
    run_job(16'h00FF, 16'hBEEF, 3, 4);

    // reset while waiting for the result: the job and its result are dropped
    acc_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0077;
    step();
    in_valid  = 1'b0;
    step();
    chk("mid_fire", 64'(acc_start), 64'd1);
    step();
    acc_ready = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_reset_state", 64'({in_ready, busy, out_valid, acc_x}), 64'({1'b1, 1'b0, 1'b0, 16'h0000}));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_reset_no_out", 64'({out_valid, busy}), 64'd0);
    end
    acc_ready  = 1'b1;
    acc_result = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stale_result_ignored", 64'({out_valid, busy}), 64'd0);
    end
    run_job(16'h0001, 16'h0042, 2, 0);

    // accelerator that never returns ready after the start pulse
    begin
      int  k_fire;
      int  k_out;
      bit  seen;
      acc_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0055;
      step();
      in_valid  = 1'b0;
      k_fire    = -1;
      k_out     = -1;
      seen      = 1'b0;
      for (int c = 1; c < 40 && !seen; c++) begin
        if (acc_start) k_fire = c;
        if (k_fire >= 0 && c > k_fire) acc_ready = 1'b0;
        if (out_valid) begin
          seen  = 1'b1;
          k_out = c;
          chk("timeout_err", 64'(out_err), 64'd1);
          chk("timeout_data", 64'(out_data), 64'd0);
        end
        if (!seen) step();
      end
`ifdef ACC_DISPATCH_TIMEOUT_EN
      chk("timeout_seen", 64'(seen), 64'd1);
      chk("timeout_delay", 64'(k_out - k_fire), 64'(TB_TIMEOUT));
      step();
      chk("timeout_out_one_cycle", 64'(out_valid), 64'd0);
      run_job(16'h0009, 16'h0BEE, 3, 2);
`else
      chk("no_timeout_fired", 64'(k_fire > 0), 64'd1);
      chk("no_timeout_out", 64'(seen), 64'd0);
      chk("no_timeout_err", 64'(out_err), 64'd0);
      chk("no_timeout_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("hang_reset_idle", 64'(in_ready), 64'd1);
      run_job(16'h0009, 16'h0BEE, 3, 2);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
